imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Sequencer and port-sharer for the single-cycle core's instruction memory.
- After reset it holds the core while a boot loader (UART/debug bridge) streams program words into IMEM through a valid/ready handshake. It then releases the core and routes fetch reads to IMEM.
- Sits between the loader, the IMEM array and the core fetch path.

Parameters:
- IMEM_DEPTH, 128, number of 32-bit words in IMEM; fetch word index >= IMEM_DEPTH is out of range.
- IDX_W, 10, width of the word index (fetch index is cpu_addr[11:2]).
- HALT_INSTR, 32'h00000063, instruction returned for out-of-range or held fetches (beq x0,x0,0 self-loop).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  request a new program load (single-cycle pulse).
- run_go  in  1  skip loading and release the core from HOLD.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks final word; qualified by ld_valid.
- ld_ready  out  1  controller accepts a word this cycle.
- ld_count  out  IDX_W+1  words accepted in the current/last load.
- ld_trunc  out  1  sticky: IMEM filled before ld_last was seen.
- cpu_addr  in  32  core fetch byte address.
- cpu_instr  out  32  instruction to the core.
- cpu_hold  out  1  core must not advance PC or commit state.
- cpu_rst_req  out  1  one-cycle pulse requesting a core PC reset to 0.
- mem_we  out  1  IMEM write enable.
- mem_idx  out  IDX_W  IMEM word index, used for both read and write.
- mem_wdata  out  32  IMEM write data.
- mem_rdata  in  32  IMEM read data (combinational read at mem_idx).

Behaviour:
- States: HOLD, LOAD, DONE, RUN; encoding is free.
- Reset (async, rst_n=0):
  - state=HOLD, ld_count=0, ld_trunc=0, cpu_rst_req=0.
  - Outputs: cpu_hold=1, ld_ready=0, mem_we=0.
- HOLD:
  - ld_start -> LOAD, clearing ld_count and ld_trunc.
  - run_go (and not ld_start) -> DONE.
  - ld_start has priority over run_go.
- LOAD:
  - ld_ready=1.
  - Accept when ld_valid&&ld_ready: mem_we=1 (combinational, same cycle), mem_idx=ld_count[IDX_W-1:0], mem_wdata=ld_data, ld_count increments at the clock edge.
  - Accepted word with ld_last=1 -> DONE.
  - Accepted word with ld_count==IMEM_DEPTH-1 and ld_last=0 -> DONE, with ld_trunc set.
  - ld_last takes precedence when both conditions hold; ld_trunc stays 0.
  - ld_start and run_go are ignored in LOAD.
  - ld_valid=0: no write, no count change, stay in LOAD indefinitely.
- DONE: exactly one cycle; cpu_rst_req=1, cpu_hold=1, ld_ready=0 -> RUN.
- RUN:
  - cpu_hold=0, ld_ready=0, mem_we=0, mem_idx=cpu_addr[11:2].
  - ld_start -> LOAD (clears ld_count, ld_trunc). cpu_hold rises in the next cycle; the current fetch completes normally.
- cpu_instr (combinational):
  - mem_rdata when state==RUN and cpu_addr[11:2] < IMEM_DEPTH.
  - HALT_INSTR otherwise, including in HOLD/LOAD/DONE.
  - cpu_addr[1:0] is ignored.
- Outside LOAD/RUN, mem_idx=0.
- Latency: a word written at edge N is readable by fetch from cycle N+1.
- Reset asserted mid-LOAD: return to HOLD immediately. Partially written IMEM contents are left unchanged; ld_count reads 0 after reset.
- ld_count saturates at IMEM_DEPTH and never wraps.

Optional Feature:
- Macro IMEM_LOAD_CSUM_EN.
- When defined:
  - Extra output ld_csum[31:0], reset 0, cleared on ld_start.
  - Each accepted LOAD word updates ld_csum <= ld_csum + ld_data (mod 2^32).
  - The value is held through DONE/RUN.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run_go=1 for 1 cycle -> one cycle of cpu_rst_req=1, then cpu_hold=0; cpu_addr=0x0 returns mem_rdata; cpu_addr=0x200 (index 128) returns 0x00000063.
- Reset, ld_start, stream 3 words 0x00500093, 0x00108113, 0x00000063 (last flagged) with ld_valid gaps -> mem_we only on valid cycles at idx 0,1,2; ld_count=3; ld_trunc=0; RUN reads back the 3 words at addr 0x0/0x4/0x8.
- Stream 128 words without ld_last -> DONE after the 128th; ld_trunc=1; ld_count=128; ld_ready=0 afterwards.
- 128th word with ld_last=1 -> ld_trunc=0, ld_count=128.
- Assert rst_n=0 after 5 of 10 words -> HOLD, cpu_hold=1, ld_count=0; new ld_start reloads from idx 0.
- In RUN, pulse ld_start -> cpu_hold=1 next cycle, cpu_instr=0x00000063, ld_ready=1; with IMEM_LOAD_CSUM_EN, loading 0xFFFFFFFF,0x00000002 gives ld_csum=0x00000001.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - IMEM boot-load sequencer and fetch port sharer
// Optional running checksum of loaded words: IMEM_LOAD_CSUM_EN
module imem_load_ctrl #(
  parameter int          IMEM_DEPTH = 128,
  parameter int          IDX_W      = 10,
  parameter logic [31:0] HALT_INSTR = 32'h00000063
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_start,
  input  logic             run_go,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic [IDX_W:0]   ld_count,
  output logic             ld_trunc,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      cpu_instr,
  output logic             cpu_hold,
  output logic             cpu_rst_req,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
`ifdef IMEM_LOAD_CSUM_EN
  output logic [31:0]      ld_csum,
`endif
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_DONE, S_RUN} state_e;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(IMEM_DEPTH);
  localparam logic [IDX_W:0] LAST_C  = DEPTH_C - 1'b1;

  state_e         state_q, state_d;
  logic [IDX_W:0] count_q, count_d;
  logic           trunc_q, trunc_d;
  logic [IDX_W-1:0] fetch_idx;
  logic           fetch_in_range;
  logic           unused_addr_bits;

  assign fetch_idx        = cpu_addr[IDX_W+1:2];
  assign fetch_in_range   = ({1'b0, fetch_idx} < DEPTH_C);
  assign unused_addr_bits = ^{cpu_addr[31:IDX_W+2], cpu_addr[1:0]};

`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0] csum_q, csum_d;
  assign ld_csum = csum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      count_q <= '0;
      trunc_q <= 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
`ifdef IMEM_LOAD_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
`ifdef IMEM_LOAD_CSUM_EN
    csum_d      = csum_q;
`endif
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_idx     = '0;
    mem_wdata   = ld_data;
    cpu_hold    = 1'b1;
    cpu_rst_req = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        if (ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
          trunc_d = 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
          csum_d  = '0;
`endif
        end else if (run_go) begin
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_idx  = count_q[IDX_W-1:0];
        if (ld_valid) begin
          mem_we = 1'b1;
          if (count_q != DEPTH_C) count_d = count_q + 1'b1;
`ifdef IMEM_LOAD_CSUM_EN
          csum_d = csum_q + ld_data;
`endif
          // ld_last wins over the full-IMEM condition, so trunc only flags a missing last
          if (ld_last) begin
            state_d = S_DONE;
          end else if (count_q == LAST_C) begin
            state_d = S_DONE;
            trunc_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        cpu_rst_req = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        mem_idx  = fetch_idx;
        if (ld_start) begin
          state_d = S_LOAD;
          count_d = '0;
          trunc_d = 1'b0;
`ifdef IMEM_LOAD_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign cpu_instr = (state_q == S_RUN && fetch_in_range) ? mem_rdata : HALT_INSTR;
  assign ld_count  = count_q;
  assign ld_trunc  = trunc_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed, table-driven bench for imem_load_ctrl
module tb_imem_load_ctrl;

  localparam logic [31:0] HALT = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst_n, ld_start, run_go, ld_valid, ld_last;
  logic [31:0] ld_data, cpu_addr, cpu_instr, mem_wdata, mem_rdata;
  logic        ld_ready, ld_trunc, cpu_hold, cpu_rst_req, mem_we;
  logic [10:0] ld_count;
  logic [9:0]  mem_idx;
`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0] ld_csum;
`endif

  imem_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .run_go(run_go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count), .ld_trunc(ld_trunc),
    .cpu_addr(cpu_addr), .cpu_instr(cpu_instr), .cpu_hold(cpu_hold),
    .cpu_rst_req(cpu_rst_req), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata),
`ifdef IMEM_LOAD_CSUM_EN
    .ld_csum(ld_csum),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // IMEM model: combinational read, write at the clock edge, pattern-filled at start
  logic [31:0] imem [128];
  logic        tb_fill;
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int k = 0; k < 128; k++) imem[k] <= 32'hA5000000 | 32'(k);
    end else if (mem_we && mem_idx < 10'd128) begin
      imem[mem_idx[6:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_idx < 10'd128) ? imem[mem_idx[6:0]] : 32'hDEADBEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  logic [31:0] stim [128];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  // Stream stim[0..n-1]; odd words are preceded by an idle cycle with ld_last high
  task automatic stream(input int n, input bit last_on_end, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        ld_valid = 1'b0;
        ld_data  = 32'hBAD0BAD0;
        ld_last  = 1'b1;
        #1;
        chk("gap_we", 32'(mem_we), 32'd0);
        chk("gap_count", 32'(ld_count), 32'(i));
        step();
      end
      ld_valid = 1'b1;
      ld_data  = stim[i];
      ld_last  = last_on_end && (i == n - 1);
      #1;
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("mem_we", 32'(mem_we), 32'd1);
      chk("mem_idx", 32'(mem_idx), 32'(i));
      chk("mem_wdata", mem_wdata, stim[i]);
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h00000000, 32'h00500093};
    vecs[1] = '{32'h00000004, 32'h00108113};
    vecs[2] = '{32'h00000008, 32'h00000063};
    vecs[3] = '{32'h0000000C, 32'hA5000003};
    vecs[4] = '{32'h00001000, 32'h00500093};
    vecs[5] = '{32'h00000007, 32'h00108113};
    vecs[6] = '{32'h000001FC, 32'hA500007F};
    vecs[7] = '{32'h00000200, HALT};
    vecs[8] = '{32'h00000FFC, HALT};

    rst_n = 1'b0; ld_start = 1'b0; run_go = 1'b0; ld_valid = 1'b0;
    ld_last = 1'b0; ld_data = '0; cpu_addr = '0; tb_fill = 1'b1;
    step();
    step();
    tb_fill = 1'b0;
    #1;
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_trunc", 32'(ld_trunc), 32'd0);
    chk("rst_rstreq", 32'(cpu_rst_req), 32'd0);
    chk("rst_instr", cpu_instr, HALT);
    rst_n = 1'b1;
    step();

    // run_go boot without a load
    run_go = 1'b1;
    #1;
    chk("go_hold0", 32'(cpu_hold), 32'd1);
    chk("go_rstreq0", 32'(cpu_rst_req), 32'd0);
    step();
    run_go = 1'b0;
    #1;
    chk("go_done_rstreq", 32'(cpu_rst_req), 32'd1);
    chk("go_done_hold", 32'(cpu_hold), 32'd1);
    chk("go_done_instr", cpu_instr, HALT);
    step();
    chk("go_run_rstreq", 32'(cpu_rst_req), 32'd0);
    chk("go_run_hold", 32'(cpu_hold), 32'd0);
    cpu_addr = 32'h0;
    #1;
    chk("go_fetch0", cpu_instr, 32'hA5000000);
    chk("go_idx0", 32'(mem_idx), 32'd0);
    cpu_addr = 32'h200;
    #1;
    chk("go_fetch128", cpu_instr, HALT);
    chk("go_idx128", 32'(mem_idx), 32'd128);

    // three-word load with idle gaps
    do_reset();
    cpu_addr = 32'h0;
    start_load();
    #1;
    chk("l3_ready", 32'(ld_ready), 32'd1);
    chk("l3_hold", 32'(cpu_hold), 32'd1);
    chk("l3_instr", cpu_instr, HALT);
    stim[0] = 32'h00500093; stim[1] = 32'h00108113; stim[2] = 32'h00000063;
    stream(3, 1'b1, 1'b1);
    cpu_addr = 32'h8;
    #1;
    chk("l3_rstreq", 32'(cpu_rst_req), 32'd1);
    chk("l3_count", 32'(ld_count), 32'd3);
    chk("l3_trunc", 32'(ld_trunc), 32'd0);
    chk("l3_done_ready", 32'(ld_ready), 32'd0);
    chk("l3_done_idx", 32'(mem_idx), 32'd0);
    step();
    for (int v = 0; v < 9; v++) begin
      cpu_addr = vecs[v].addr;
      #1;
      chk($sformatf("fetch_vec%0d", v), cpu_instr, vecs[v].exp);
    end

    // 128 words without ld_last: truncation
    do_reset();
    start_load();
    for (int i = 0; i < 128; i++) stim[i] = 32'hC0DE0000 + 32'(i);
    stream(128, 1'b0, 1'b0);
    ld_valid = 1'b1;
    #1;
    chk("tr_trunc", 32'(ld_trunc), 32'd1);
    chk("tr_count", 32'(ld_count), 32'd128);
    chk("tr_ready", 32'(ld_ready), 32'd0);
    chk("tr_done_we", 32'(mem_we), 32'd0);
    chk("tr_rstreq", 32'(cpu_rst_req), 32'd1);
    step();
    cpu_addr = 32'h1FC;
    #1;
    chk("tr_run_ready", 32'(ld_ready), 32'd0);
    chk("tr_run_we", 32'(mem_we), 32'd0);
    chk("tr_run_hold", 32'(cpu_hold), 32'd0);
    chk("tr_fetch127", cpu_instr, 32'hC0DE007F);
    chk("tr_count_held", 32'(ld_count), 32'd128);
    ld_valid = 1'b0;

    // reload from RUN; 128th word carries ld_last
    cpu_addr = 32'h4;
    ld_start = 1'b1;
    #1;
    chk("rl_hold_now", 32'(cpu_hold), 32'd0);
    chk("rl_fetch_now", cpu_instr, 32'hC0DE0001);
    step();
    ld_start = 1'b0;
    #1;
    chk("rl_hold_next", 32'(cpu_hold), 32'd1);
    chk("rl_instr_next", cpu_instr, HALT);
    chk("rl_ready", 32'(ld_ready), 32'd1);
    chk("rl_count_clr", 32'(ld_count), 32'd0);
    chk("rl_trunc_clr", 32'(ld_trunc), 32'd0);
    for (int i = 0; i < 128; i++) stim[i] = 32'h5EED0000 + 32'(i);
    stream(128, 1'b1, 1'b0);
    #1;
    chk("lst_trunc", 32'(ld_trunc), 32'd0);
    chk("lst_count", 32'(ld_count), 32'd128);
    chk("lst_rstreq", 32'(cpu_rst_req), 32'd1);
    step();

    // reset mid-load, then reload from index 0
    do_reset();
    ld_start = 1'b1;
    run_go   = 1'b1;
    step();
    ld_start = 1'b0;
    run_go   = 1'b0;
    #1;
    chk("prio_ready", 32'(ld_ready), 32'd1);
    chk("prio_rstreq", 32'(cpu_rst_req), 32'd0);
    for (int i = 0; i < 10; i++) stim[i] = 32'h0F000000 + 32'(i);
    stream(5, 1'b0, 1'b0);
    ld_start = 1'b1;
    run_go   = 1'b1;
    step();
    ld_start = 1'b0;
    run_go   = 1'b0;
    #1;
    chk("ign_ready", 32'(ld_ready), 32'd1);
    chk("ign_count", 32'(ld_count), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mr_hold", 32'(cpu_hold), 32'd1);
    chk("mr_count", 32'(ld_count), 32'd0);
    chk("mr_ready", 32'(ld_ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start_load();
    stim[0] = 32'hFFFFFFFF;
    stim[1] = 32'h00000002;
    stream(2, 1'b1, 1'b0);
    #1;
    chk("cs_count", 32'(ld_count), 32'd2);
    chk("cs_trunc", 32'(ld_trunc), 32'd0);
`ifdef IMEM_LOAD_CSUM_EN
    chk("cs_sum_done", ld_csum, 32'h00000001);
`endif
    step();
    cpu_addr = 32'h0;
    #1;
    chk("cs_fetch0", cpu_instr, 32'hFFFFFFFF);
    cpu_addr = 32'h10;
    #1;
    chk("cs_fetch_partial", cpu_instr, 32'h0F000004);
`ifdef IMEM_LOAD_CSUM_EN
    chk("cs_sum_run", ld_csum, 32'h00000001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
